// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller with one 32-bit word per line.
// Valid/dirty/tag state lives here; the data array sits outside and is read combinationally.
module dcache_ctrl #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req_valid,
  input  logic               cpu_req_rw,
  input  logic [31:0]        cpu_req_addr,
  input  logic [31:0]        cpu_req_wdata,
  output logic               cpu_ready,
  output logic [31:0]        cpu_rdata,
  output logic               mem_req_valid,
  output logic               mem_req_rw,
  output logic [31:0]        mem_req_addr,
  output logic [31:0]        mem_req_wdata,
  input  logic               mem_ready,
  input  logic [31:0]        mem_rdata,
  output logic [INDEX_W-1:0] data_index,
  output logic               data_we,
  output logic [31:0]        data_wdata,
  input  logic [31:0]        data_rdata
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e             state_q, state_d;
  logic               rw_q;
  logic [31:2]        addr_q;
  logic [31:0]        wdata_q;
  logic [LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q [LINES];

  logic               accept, valid_set, dirty_set, dirty_clr, tag_we, hit;
  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tagl_q;

  // Byte-offset bits never select anything in a one-word line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  assign idx_q  = addr_q[INDEX_W+1:2];
  assign tagl_q = addr_q[31:INDEX_W+2];
  assign hit    = valid_q[idx_q] && (tag_q[idx_q] == tagl_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (valid_set) valid_q[idx_q] <= 1'b1;
      if (dirty_set)      dirty_q[idx_q] <= 1'b1;
      else if (dirty_clr) dirty_q[idx_q] <= 1'b0;
    end
  end

  // Request latch and tag store carry no reset: tags are meaningless while valid=0.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= cpu_req_rw;
      addr_q  <= cpu_req_addr[31:2];
      wdata_q <= cpu_req_wdata;
    end
    if (tag_we) tag_q[idx_q] <= tagl_q;
  end

  always_comb begin
    state_d       = state_q;
    cpu_ready     = 1'b0;
    cpu_rdata     = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    data_index    = idx_q;
    data_we       = 1'b0;
    data_wdata    = '0;
    accept        = 1'b0;
    valid_set     = 1'b0;
    dirty_set     = 1'b0;
    dirty_clr     = 1'b0;
    tag_we        = 1'b0;
    case (state_q)
      IDLE: begin
        data_index = cpu_req_addr[INDEX_W+1:2];
        if (cpu_req_valid) begin
          accept  = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          state_d   = IDLE;
          if (rw_q) begin
            data_we    = 1'b1;
            data_wdata = wdata_q;
            dirty_set  = 1'b1;
          end else begin
            cpu_rdata = data_rdata;
          end
        end else if (valid_q[idx_q] && dirty_q[idx_q]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_q[idx_q], idx_q, 2'b00};
        mem_req_wdata = data_rdata;
        if (mem_ready) begin
          dirty_clr = 1'b1;
          state_d   = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q, 2'b00};
        if (mem_ready) begin
          data_we    = 1'b1;
          data_wdata = mem_rdata;
          valid_set  = 1'b1;
          tag_we     = 1'b1;
          dirty_clr  = 1'b1;
          state_d    = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: external data array, a fixed-latency backing memory, a vector table
// of CPU transactions checked through a scoreboard, and hand sequences for reset and streaming.
module tb_dcache_ctrl;

  localparam int IW      = 10;
  localparam int MEM_LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cpu_req_valid, cpu_req_rw;
  logic [31:0]   cpu_req_addr, cpu_req_wdata;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic          mem_req_valid, mem_req_rw;
  logic [31:0]   mem_req_addr, mem_req_wdata;
  logic          mem_ready, mem_ready_resp, mem_ready_spur;
  logic [31:0]   mem_rdata;
  logic [IW-1:0] data_index;
  logic          data_we;
  logic [31:0]   data_wdata, data_rdata;

  logic [31:0] dmem [1 << IW];
  logic [31:0] bmem [logic [31:0]];

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mtx_t;
  mtx_t mem_log[$];

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        exp_wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic        exp_fill;
    logic [31:0] fill_addr;
  } vec_t;

  int errors = 0;
  int checks = 0;

  dcache_ctrl #(.INDEX_W(IW), .TAG_W(30 - IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_rw    (cpu_req_rw),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_ready     (cpu_ready),
    .cpu_rdata     (cpu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .data_index    (data_index),
    .data_we       (data_we),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata)
  );

  always #5 clk = ~clk;

  assign data_rdata = dmem[data_index];
  assign mem_ready  = mem_ready_resp | mem_ready_spur;

  always @(posedge clk) if (data_we) dmem[data_index] <= data_wdata;

  // Backing memory: answers every request on its MEM_LAT-th cycle.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready_resp = 1'b0;
      if (rst_n && mem_req_valid) begin
        cnt++;
        if (cnt == MEM_LAT) begin
          cnt = 0;
          mem_ready_resp = 1'b1;
          mem_log.push_back('{mem_req_rw, mem_req_addr, mem_req_wdata});
          if (mem_req_rw) bmem[mem_req_addr] = mem_req_wdata;
          else mem_rdata = bmem.exists(mem_req_addr) ? bmem[mem_req_addr]
                                                     : (mem_req_addr ^ 32'h5A5A_0000);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input int lat, input logic wb,
                              input logic [31:0] wb_addr, input logic [31:0] wb_data,
                              input logic fill, input logic [31:0] fill_addr);
    vec_t v;
    v.rw = rw; v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_lat = lat;
    v.exp_wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.exp_fill = fill; v.fill_addr = fill_addr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int   n0, lat, fi;
    bit   got;
    exp_t e;
    n0 = mem_log.size();
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = v.rw;
    cpu_req_addr  = v.addr;
    cpu_req_wdata = v.wdata;
    sb.push_back('{!v.rw, v.exp_rd, v.exp_lat});
    #1 chk($sformatf("v%0d idle_index", id), 32'(data_index), 32'(v.addr[IW+1:2]));
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      cpu_req_valid = 1'b0;
      lat++;
      if (cpu_ready) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL v%0d timeout: no cpu_ready after %0d cycles", id, lat);
    end else begin
      chk($sformatf("v%0d latency", id), 32'(lat), 32'(e.lat));
      if (e.chk_rd) chk($sformatf("v%0d rdata", id), cpu_rdata, e.rd);
    end
    chk($sformatf("v%0d mem_count", id), 32'(mem_log.size() - n0), 32'(int'(v.exp_wb) + int'(v.exp_fill)));
    if (v.exp_wb && mem_log.size() > n0) begin
      chk($sformatf("v%0d wb_rw", id), 32'(mem_log[n0].rw), 32'd1);
      chk($sformatf("v%0d wb_addr", id), mem_log[n0].addr, v.wb_addr);
      chk($sformatf("v%0d wb_data", id), mem_log[n0].wdata, v.wb_data);
    end
    fi = n0 + (v.exp_wb ? 1 : 0);
    if (v.exp_fill && mem_log.size() > fi) begin
      chk($sformatf("v%0d fill_rw", id), 32'(mem_log[fi].rw), 32'd0);
      chk($sformatf("v%0d fill_addr", id), mem_log[fi].addr, v.fill_addr);
    end
  endtask

  initial begin
    vec_t vecs[13];
    int   pulses, n0;

    cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_ready_spur = 1'b0;
    bmem[32'h0000_0040] = 32'hDEAD_BEEF;
    bmem[32'h0000_1040] = 32'hCAFE_F00D;
    bmem[32'h0000_2040] = 32'h0BAD_C0DE;
    bmem[32'h0000_0080] = 32'h1111_2222;

    //           rw    addr           wdata          exp_rd         lat wb    wb_addr        wb_data        fill  fill_addr
    vecs[0]  = mk(1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 5, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0040);
    vecs[1]  = mk(1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
    vecs[2]  = mk(1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0,         1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
    vecs[3]  = mk(1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
    vecs[4]  = mk(1'b0, 32'h0000_1040, 32'h0,         32'hCAFE_F00D, 8, 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b1, 32'h0000_1040);
    vecs[5]  = mk(1'b0, 32'h0000_2040, 32'h0,         32'h0BAD_C0DE, 5, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_2040);
    vecs[6]  = mk(1'b0, 32'h0000_0043, 32'h0,         32'h1234_5678, 5, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0040);
    vecs[7]  = mk(1'b1, 32'h0000_0080, 32'hAAAA_5555, 32'h0,         5, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0080);
    vecs[8]  = mk(1'b0, 32'h0000_0080, 32'h0,         32'hAAAA_5555, 1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
    vecs[9]  = mk(1'b0, 32'h0000_0FFC, 32'h0,         32'h5A5A_0FFC, 5, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0FFC);
    vecs[10] = mk(1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_FFFC, 5, 1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFC);
    vecs[11] = mk(1'b1, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 32'h0,         1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
    vecs[12] = mk(1'b0, 32'h0000_0FFC, 32'h0,         32'h5A5A_0FFC, 8, 1'b1, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 1'b1, 32'h0000_0FFC);

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst mem_req_rw", 32'(mem_req_rw), 32'd0);
    chk("rst data_we", 32'(data_we), 32'd0);
    chk("rst cpu_rdata", cpu_rdata, 32'd0);
    chk("rst mem_req_addr", mem_req_addr, 32'd0);
    chk("rst mem_req_wdata", mem_req_wdata, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Request held high: one hit every two cycles, no memory traffic.
    n0 = mem_log.size();
    pulses = 0;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0000_0080;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_ready) begin
        pulses++;
        chk($sformatf("b2b rdata %0d", pulses), cpu_rdata, 32'hAAAA_5555);
      end
    end
    cpu_req_valid = 1'b0;
    chk("b2b pulses", 32'(pulses), 32'd4);
    chk("b2b mem_count", 32'(mem_log.size() - n0), 32'd0);

    // Stray mem_ready while idle must be ignored.
    @(negedge clk);
    mem_ready_spur = 1'b1;
    @(negedge clk);
    mem_ready_spur = 1'b0;
    chk("spur mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("spur cpu_ready", 32'(cpu_ready), 32'd0);
    chk("spur data_we", 32'(data_we), 32'd0);
    run_vec(mk(1'b0, 32'h0000_0080, 32'h0, 32'hAAAA_5555, 1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0), 100);

    // Reset in the middle of a fill.
    n0 = mem_log.size();
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0000_1040;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    chk("mid mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("mid mem_req_addr", mem_req_addr, 32'h0000_1040);
    #1 rst_n = 1'b0;
    #1;
    chk("arst mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("arst mem_req_addr", mem_req_addr, 32'd0);
    chk("arst data_we", 32'(data_we), 32'd0);
    chk("arst cpu_ready", 32'(cpu_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("arst mem_count", 32'(mem_log.size() - n0), 32'd0);
    chk("arst dmem untouched", dmem[10'h010], 32'h1234_5678);
    run_vec(mk(1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 5, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0040), 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter INDEX_W, default 10, meaning line-index width (2**INDEX_W lines, one 32-bit word per line).
REQ-002 Parameter TAG_W, default 20, meaning tag width, equal to 30-INDEX_W.
REQ-003 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_rw  in  1  1 = write, 0 = read.
- cpu_req_addr  in  32  byte address; bits [1:0] ignored.
- cpu_req_wdata  in  32  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data, valid while cpu_ready=1.
- mem_req_valid  out  1  backing-memory request.
- mem_req_rw  out  1  1 = writeback, 0 = fill.
- mem_req_addr  out  32  word-aligned memory address.
- mem_req_wdata  out  32  writeback data.
- mem_ready  in  1  memory completion; fill data valid in the same cycle.
- mem_rdata  in  32  fill data.
- data_index  out  INDEX_W  data-array index.
- data_we  out  1  data-array write enable.
- data_wdata  out  32  data-array write data.
- data_rdata  in  32  data-array combinational read of data_index.

Function
REQ-004 The address split SHALL be: index = addr[INDEX_W+1:2]; tag = addr[31:INDEX_W+2].
REQ-005 Valid, dirty and tag arrays (2**INDEX_W entries each) SHALL be internal registers; the data array is external.
REQ-006 The FSM SHALL have states IDLE, COMPARE, WRITEBACK and ALLOCATE.
REQ-007 IDLE: when cpu_req_valid=1, the block SHALL latch rw, addr and wdata and go to COMPARE; cpu_req_* SHALL be ignored in every other state.
REQ-008 data_index SHALL equal the latched index in every state except IDLE; in IDLE it SHALL equal the index of cpu_req_addr.
REQ-009 COMPARE, hit (valid=1 and tag match): cpu_ready=1 for exactly one cycle; go to IDLE.
- Read hit: cpu_rdata = data_rdata.
- Write hit: data_we=1, data_wdata = latched wdata, dirty set to 1.
- Hit latency: cpu_ready asserts 1 cycle after acceptance.
REQ-010 COMPARE, miss: if valid=1 and dirty=1, go to WRITEBACK; otherwise go to ALLOCATE.
REQ-011 WRITEBACK: mem_req_valid=1, mem_req_rw=1, mem_req_addr = {stored tag, index, 2'b00}, mem_req_wdata = data_rdata; hold all of these until mem_ready=1, then clear dirty and go to ALLOCATE.
REQ-012 ALLOCATE: mem_req_valid=1, mem_req_rw=0, mem_req_addr = {latched addr[31:2], 2'b00}; hold until mem_ready=1.
REQ-013 On mem_ready=1 in ALLOCATE, the block SHALL set data_we=1 and data_wdata = mem_rdata, set valid=1, set tag = latched tag, set dirty=0, and go to COMPARE; the following COMPARE then hits per REQ-009.
REQ-014 mem_req_valid SHALL be 0 in IDLE and COMPARE.
REQ-015 data_we SHALL be 0 except in the cases of REQ-009 and REQ-013.
REQ-016 cpu_ready SHALL never assert in any state except COMPARE.
REQ-017 If mem_ready=1 is sampled while mem_req_valid=0, it SHALL have no effect.
REQ-018 A cpu_req_valid held high after completion SHALL be accepted as a new request in the IDLE cycle after cpu_ready, giving back-to-back hits one completion every 2 cycles.

Reset
REQ-019 While rst_n=0, asynchronously: state = IDLE; all valid and dirty bits = 0; cpu_ready, mem_req_valid, mem_req_rw and data_we = 0; cpu_rdata, mem_req_addr and mem_req_wdata = 0.
REQ-020 Tag contents after reset SHALL be don't-care.
REQ-021 Reset asserted during WRITEBACK or ALLOCATE SHALL abandon the transaction, with no data-array write and no cpu_ready.

Verification
REQ-022 Cold read 0x0000_0040, mem returns 0xDEAD_BEEF after 3 cycles -> one fill request to 0x40; cpu_ready with cpu_rdata = 0xDEAD_BEEF; repeat read hits in 1 cycle with no mem request.
REQ-023 Write 0x1234_5678 to 0x40 after fill, then read 0x40 -> write hit with no mem traffic; read returns 0x1234_5678.
REQ-024 Dirty line at 0x40, then read 0x0000_1040 (same index, INDEX_W=10) -> writeback to 0x40 with data 0x1234_5678, then fill from 0x1040, then cpu_ready.
REQ-025 Clean conflict miss -> no writeback; fill only.
REQ-026 rst_n low mid-ALLOCATE, then read 0x40 -> outputs zero immediately on reset; the read after reset misses (valid cleared) and issues a fresh fill.
REQ-027 cpu_req_valid held high across 4 hits -> 4 cpu_ready pulses in 8 cycles; spurious mem_ready in IDLE -> no state change.
